// File: rtl/pp_accumulator_163.sv
// pp_accumulator_163: accumulates shifted carry-less 11x11 partial products into
// a 329-bit product, optionally folding it modulo x^163+x^7+x^6+x^3+1.
// Build option: define GF163_REDUCE_EN to enable the two-fold reduction and a
// 163-bit result; otherwise the raw 329-bit product is presented.
module pp_accumulator_163 #(
    parameter int unsigned WORD   = 11,
    parameter int unsigned NSHIFT = 29,
    localparam int unsigned PP_W    = 2 * WORD - 1,
    localparam int unsigned SHIFT_W = $clog2(NSHIFT),
    localparam int unsigned ACC_W   = WORD * (NSHIFT - 1) + PP_W,
`ifdef GF163_REDUCE_EN
    localparam int unsigned RES_W   = 163
`else
    localparam int unsigned RES_W   = ACC_W
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pp_valid,
    input  logic [PP_W-1:0]    pp_in,
    input  logic [SHIFT_W-1:0] pp_shift,
    input  logic               pp_last,
    output logic               pp_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [RES_W-1:0]   res_data,
    output logic               shift_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC  = 3'd1,
        RED1 = 3'd2,
        RED2 = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               shift_err_q, shift_err_d;

`ifdef GF163_REDUCE_EN
    localparam int unsigned FIELD_W = 163;
    localparam int unsigned HI_W    = ACC_W - FIELD_W;

    logic [HI_W-1:0]  hi;
    logic [ACC_W-1:0] fold;

    // One reduction step: bits at or above x^163 are folded back through x^7+x^6+x^3+1.
    always_comb begin
        hi   = acc_q[ACC_W-1:FIELD_W];
        fold = ACC_W'(acc_q[FIELD_W-1:0]) ^ ACC_W'(hi) ^ (ACC_W'(hi) << 3)
             ^ (ACC_W'(hi) << 6) ^ (ACC_W'(hi) << 7);
    end
`endif

    // Accumulator may take a beat only in ACC and never while a restart is requested.
    assign pp_ready  = (state_q == ACC) && !start;
    assign res_valid = (state_q == DONE);
    assign res_data  = acc_q[RES_W-1:0];
    assign shift_err = shift_err_q;

    // Next-state, accumulator and error-flag update.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        shift_err_d = shift_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ACC;
                    acc_d       = '0;
                    shift_err_d = 1'b0;
                end
            end
            ACC: begin
                if (start) begin
                    acc_d       = '0;
                    shift_err_d = 1'b0;
                end else if (pp_valid) begin
                    if (pp_shift >= SHIFT_W'(NSHIFT)) begin
                        shift_err_d = 1'b1;
                    end else begin
                        acc_d = acc_q ^ (ACC_W'(pp_in) << (WORD * 32'(pp_shift)));
                    end
                    if (pp_last) begin
`ifdef GF163_REDUCE_EN
                        state_d = RED1;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef GF163_REDUCE_EN
            RED1: begin
                acc_d   = fold;
                state_d = RED2;
            end
            RED2: begin
                acc_d   = fold;
                state_d = DONE;
            end
`endif
            DONE: begin
                if (start) begin
                    state_d     = ACC;
                    acc_d       = '0;
                    shift_err_d = 1'b0;
                end else if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            shift_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            shift_err_q <= shift_err_d;
        end
    end

endmodule

// File: doc/pp_accumulator_163.md
PP_ACCUMULATOR_163 -- requirements
Module: pp_accumulator_163

Interface
REQ-001 SHALL have parameter WORD, default 11: bit width of one operand word of the partial-product multiplier.
REQ-002 SHALL have parameter NSHIFT, default 29: number of legal word offsets, 0..28.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin a new product and clear the accumulator.
REQ-006 SHALL have port pp_valid, input, 1: partial product present.
REQ-007 SHALL have port pp_in, input, 21: carry-less 11x11 partial product.
REQ-008 SHALL have port pp_shift, input, 5: word offset k; pp_in is placed at bit 11*k.
REQ-009 SHALL have port pp_last, input, 1: final partial product of this product.
REQ-010 SHALL have port pp_ready, output, 1: accumulator accepts pp this cycle.
REQ-011 SHALL have port res_valid, output, 1: result available.
REQ-012 SHALL have port res_ready, input, 1: consumer accepts result.
REQ-013 SHALL have port res_data, output, RES_W: RES_W = 163 with GF163_REDUCE_EN defined, else 329.
REQ-014 SHALL have port shift_err, output, 1: sticky flag, out-of-range pp_shift seen.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, RED1, RED2, DONE.
REQ-016 SHALL move IDLE->ACC or DONE->ACC on start=1 and clear the 329-bit accumulator and shift_err.
REQ-017 SHALL drive pp_ready = (state==ACC) && !start, combinationally.
REQ-018 SHALL, on pp_valid&&pp_ready, XOR pp_in into accumulator bits [11*k+20 : 11*k].
REQ-019 SHALL, for pp_shift>28, accept the beat, leave the accumulator unchanged, and set shift_err.
REQ-020 SHALL, on start=1 in ACC, restart: clear the accumulator, drop any concurrent pp beat, and stay in ACC.
REQ-021 SHALL, on an accepted beat with pp_last=1, go to DONE (macro off) or RED1 (macro on).
REQ-022 SHALL, in RED1 and RED2, each fold the accumulator once mod f(x)=x^163+x^7+x^6+x^3+1: acc = acc[162:0] ^ H ^ H<<3 ^ H<<6 ^ H<<7, with H = acc[328:163].
REQ-023 SHALL advance RED1->RED2->DONE in one cycle each; two folds SHALL leave degree <163.
REQ-024 SHALL assert res_valid only in DONE; res_data = accumulator low RES_W bits.
REQ-025 SHALL hold res_data stable while res_valid=1 and res_ready=0.
REQ-026 SHALL go DONE->IDLE on res_ready=1; start has priority over res_ready in DONE.
REQ-027 SHALL have latency from last accepted beat (cycle T) to res_valid: T+1 with macro off, T+3 with macro on.
REQ-028 SHALL ignore pp_valid outside ACC; no accumulator change.

Reset
REQ-029 SHALL, when rst_n=0 at a clock edge, enter IDLE, clear the accumulator, and drive res_valid=0, shift_err=0, pp_ready=0, res_data=0.
REQ-030 SHALL abort any in-flight product on reset in ACC, RED1, RED2 or DONE; the next product SHALL be uncorrupted.

Configuration
REQ-031 SHALL, with GF163_REDUCE_EN defined, include RED1/RED2 and output the 163-bit reduced field element.
REQ-032 SHALL, without GF163_REDUCE_EN, omit RED1/RED2 logic and output the raw 329-bit carry-less product.

Verification
REQ-033 SHALL verify: start; pp_in=21'h1, shift=0, last -> res_data=1 (either config), at the configured latency.
REQ-034 SHALL verify: macro on; pp_in=21'h1, shift=15, last -> res_data=163'h324, res_valid at T+3.
REQ-035 SHALL verify: two beats pp_in=21'h1FFFFF at shift=3, second with last -> res_data=0.
REQ-036 SHALL verify: pp_shift=30 beat then a valid last beat -> shift_err=1, result equals the valid beat only.
REQ-037 SHALL verify: res_ready held 0 for 5 cycles in DONE -> res_valid and res_data unchanged; release -> IDLE next cycle.
REQ-038 SHALL verify: rst_n=0 mid-ACC after 3 beats, then a new single-beat product -> result reflects only the new beat.
